johnson_dff: RTL and testbench

// - WIDTH-stage Johnson (twisted-ring) counter built from D flip-flops.
// - Every stage has its own synchronous active-low reset and preset, so any

---
 rtl/johnson_pkg.sv | 24 ++
 rtl/johnson_dff_pr.sv | 33 +++
 rtl/johnson_dff.sv | 64 ++++++
 tb/tb_johnson_dff.sv | 139 +++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared constants and reference next-state function for the Johnson counter.
package johnson_pkg;

    localparam int JOHNSON_WIDTH_DEFAULT = 4;
    localparam int JOHNSON_MAX_WIDTH     = 32;
    localparam int PERIOD                = 2 * JOHNSON_WIDTH_DEFAULT;

    // Twisted-ring step: stage 0 takes the inverted last stage, all others shift up.
    function automatic logic [JOHNSON_MAX_WIDTH-1:0] johnson_next(
        input logic [JOHNSON_MAX_WIDTH-1:0] q,
        input int                           width = JOHNSON_WIDTH_DEFAULT
    );
        logic [JOHNSON_MAX_WIDTH-1:0] n;
        n    = '0;
        n[0] = ~q[width-1];
        for (int i = 1; i < JOHNSON_MAX_WIDTH; i++) begin
            if (i < width) begin
                n[i] = q[i-1];
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/johnson_dff_pr.sv
// Single D flip-flop with synchronous active-low reset and preset; reset has priority.
module dff_pr
    import johnson_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pre_n,
    input  logic d,
    output logic q,
    output logic qb
);

    logic state_q;
    logic state_d;

    always_comb begin
        state_d = d;
        if (!rst_n) begin
            state_d = 1'b0;
        end else if (!pre_n) begin
            state_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // Complement taken from the register so it cannot glitch.
    assign q  = state_q;
    assign qb = ~state_q;

endmodule

// File: rtl/johnson_dff.sv
// WIDTH-stage Johnson counter built from per-stage reset/preset flip-flops.
module johnson_dff
    import johnson_pkg::*;
#(
    parameter int WIDTH = JOHNSON_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] rst,
    input  logic [WIDTH-1:0] preset,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] ringD;
    logic             unusedSerial;

    // d is a reserved interface pin and deliberately never reaches the ring.
    assign unusedSerial = d;
    assign ringD        = {q[WIDTH-2:0], ~q[WIDTH-1]};

    for (genvar i = 0; i < WIDTH; i++) begin : gStage
        dff_pr uStage (
            .clk   (clk),
            .rst_n (rst[i]),
            .pre_n (preset[i]),
            .d     (ringD[i]),
            .q     (q[i]),
            .qb    (qb[i])
        );
    end

`ifndef SYNTHESIS
    logic                         seenReset_q;
    logic                         checkArmed_q;
    logic                         prevRun_q;
    logic [WIDTH-1:0]             prevQ_q;
    logic [JOHNSON_MAX_WIDTH-1:0] expectNext;

    always_ff @(posedge clk) begin
        if (rst == '0) begin
            seenReset_q <= 1'b1;
        end
        checkArmed_q <= seenReset_q;
        prevRun_q    <= (&rst) && (&preset);
        prevQ_q      <= q;
    end

    assign expectNext = johnson_next(JOHNSON_MAX_WIDTH'(prevQ_q), WIDTH);

    // Checks only start once every stage has been forced to a known value.
    always_ff @(posedge clk) begin
        if (seenReset_q) begin
            assert (qb == ~q)
                else $error("qb is not the complement of q");
        end
        if (checkArmed_q && prevRun_q) begin
            assert (q == expectNext[WIDTH-1:0])
                else $error("ring step does not match johnson_next");
        end
    end
`endif

endmodule

// File: tb/tb_johnson_dff.sv
// Self-checking bench for johnson_dff: arithmetic scoreboard plus hand-computed vectors.
module tb_johnson_dff;

    logic       clk;
    logic [3:0] rst;
    logic [3:0] preset;
    logic       d;
    logic [3:0] q;
    logic [3:0] qb;

    int         asserts;
    int         failures;
    logic [3:0] expQ;
    logic       modelValid;
    logic [3:0] refSeq [32];

    johnson_dff #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .preset (preset),
        .d      (d),
        .q      (q),
        .qb     (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counting treats the state as a number: double it and feed in the inverted top bit.
    function automatic logic [3:0] modelNext(input logic [3:0] cur, input logic [3:0] r,
                                             input logic [3:0] p);
        int v;
        int s;
        v = int'(cur);
        s = ((v * 2) + (1 - v / 8)) % 16;
        s = (s | int'(~p)) & int'(r);
        return 4'(s);
    endfunction

    always @(posedge clk) begin
        expQ       <= modelNext(expQ, rst, preset);
        modelValid <= modelValid | (rst == 4'b0000);
    end

    always @(negedge clk) begin
        if (modelValid) begin
            asserts++;
            if (q !== expQ || qb !== ~expQ) begin
                failures++;
                $display("[TB] FAIL scoreboard: q=%b qb=%b, required q=%b qb=%b",
                         q, qb, expQ, ~expQ);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] p);
        rst    = r;
        preset = p;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp);
        asserts++;
        if (q !== exp || qb !== ~exp) begin
            failures++;
            $display("[TB] FAIL %s: q=%b qb=%b, required q=%b qb=%b", name, q, qb, exp, ~exp);
        end
    endtask

    initial begin
        logic [3:0] seq [8];
        seq = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
        asserts    = 0;
        failures   = 0;
        modelValid = 1'b0;
        expQ       = 4'b0000;
        rst        = 4'b1111;
        preset     = 4'b1111;
        d          = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        applyStimulus(4'b0000, 4'b1111);
        checkOutput("fullReset", 4'b0000);

        applyStimulus(4'b0001, 4'b1110);
        checkOutput("seedLoad", 4'b0001);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 4'b1111);
            checkOutput($sformatf("count%0d", i), seq[i]);
        end

        applyStimulus(4'b0000, 4'b0000);
        checkOutput("resetWins", 4'b0000);

        repeat (3) applyStimulus(4'b1111, 4'b1111);
        checkOutput("midRunStart", 4'b0111);
        applyStimulus(4'b1111, 4'b0111);
        checkOutput("midRunPreset", 4'b1111);
        applyStimulus(4'b1111, 4'b1111);
        checkOutput("midRunRelease1", 4'b1110);
        applyStimulus(4'b1111, 4'b1111);
        checkOutput("midRunRelease2", 4'b1100);

        // Reference run with d held low, then the same run with d toggling.
        applyStimulus(4'b0000, 4'b1111);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(4'b1111, 4'b1111);
            refSeq[i] = q;
        end
        applyStimulus(4'b0000, 4'b1111);
        for (int i = 0; i < 32; i++) begin
            d = 1'($urandom_range(0, 1));
            applyStimulus(4'b1111, 4'b1111);
            asserts++;
            if (q !== refSeq[i]) begin
                failures++;
                $display("[TB] FAIL dIgnored%0d: q=%b, required q=%b", i, q, refSeq[i]);
            end
        end
        d = 1'b0;

        applyStimulus(4'b0101, 4'b1010);
        checkOutput("oddSeed", 4'b0101);
        applyStimulus(4'b1111, 4'b1111);
        checkOutput("oddSeedStep1", 4'b1011);
        applyStimulus(4'b1111, 4'b1111);
        checkOutput("oddSeedStep2", 4'b0110);
        repeat (6) applyStimulus(4'b1111, 4'b1111);
        checkOutput("oddSeedPeriod", 4'b0101);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
